// File: rtl/keypad_lock_ctrl_pkg.sv
// Shared types and helpers for the keypad lock controller.
package keypad_lock_ctrl_pkg;

  localparam int unsigned KEYS  = 10;
  localparam int unsigned NIB_W = 4;

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_SET     = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  // One-hot keypad lines to BCD digit.
  function automatic logic [NIB_W-1:0] key_encode(input logic [KEYS-1:0] keys);
    logic [NIB_W-1:0] d;
    d = '0;
    for (int i = 0; i < int'(KEYS); i++) begin
      if (keys[i]) d = NIB_W'(i);
    end
    return d;
  endfunction

  function automatic logic [NIB_W-1:0] bcd_inc(input logic [NIB_W-1:0] v);
    return (v >= 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_if.sv
// Keypad-side inputs and actuator/status outputs of the lock controller.
interface keypad_lock_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  logic [keypad_lock_ctrl_pkg::KEYS-1:0] key_in;
  logic             enter;
  logic             clear;
  logic             lock;
  logic             mode_sel;
  logic             unlocked;
  logic             locked_out;
  logic             programming;
  logic [CNT_W-1:0] entry_count;
  logic [3:0]       digit_out;
  logic             digit_valid;
  logic             key_err;
  logic             match;
  logic             fail;
  logic             code_set;
  logic [3:0]       attempt_count;

  modport master (
    output key_in, enter, clear, lock, mode_sel,
    input  unlocked, locked_out, programming, entry_count, digit_out,
           digit_valid, key_err, match, fail, code_set, attempt_count
  );

  modport slave (
    input  key_in, enter, clear, lock, mode_sel,
    output unlocked, locked_out, programming, entry_count, digit_out,
           digit_valid, key_err, match, fail, code_set, attempt_count
  );
endinterface

// File: rtl/keypad_lock_ctrl_key_press_detect.sv
// Press edge detection: a new press only counts when all keys were released.
module key_press_detect
  import keypad_lock_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [KEYS-1:0] key_in,
  output logic [3:0]      digit_c,
  output logic            digit_strobe_c,
  output logic            key_err_c
);

  logic [KEYS-1:0] key_q;
  logic            press_c;
  logic            onehot_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_q <= '0;
    else      key_q <= key_in;
  end

  assign press_c        = (key_q == '0) && (key_in != '0);
  assign onehot_c       = ((key_in & (key_in - KEYS'(1))) == '0);
  assign digit_strobe_c = press_c && onehot_c;
  assign key_err_c      = press_c && !onehot_c;
  assign digit_c        = key_encode(key_in);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock: digit buffer, code compare, attempt counting, lockout timer and reprogramming.
module keypad_lock_ctrl
  import keypad_lock_ctrl_pkg::*;
#(
  parameter int unsigned          DIGITS         = 8,
  parameter int unsigned          MIN_LEN        = 4,
  parameter int unsigned          MAX_ATTEMPTS   = 3,
  parameter int unsigned          LOCKOUT_CYCLES = 1024,
  parameter logic [DIGITS*4-1:0]  DEFAULT_CODE   = 32'h21935488,
  parameter int unsigned          DEFAULT_LEN    = 8
)(
  input  logic               clk,
  input  logic               rst,
  keypad_lock_ctrl_if.slave  bus
);

  localparam int unsigned BUF_W = DIGITS * NIB_W;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam int unsigned TMR_W = $clog2(LOCKOUT_CYCLES);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d, code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic [3:0]         attempt_q, attempt_d, attempt_inc;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [3:0]         digit_out_q, digit_out_d;
  logic               digit_valid_q, digit_valid_d, key_err_q, key_err_d;
  logic               match_q, match_d, fail_q, fail_d, code_set_q, code_set_d;
  logic               unlocked_q, locked_out_q, programming_q;
  logic               enter_q, clear_q, lock_q;
  logic               enter_p, clear_p, lock_p;
  logic               clr_buf, take_digit, code_ok;
  logic [3:0]         digit_c;
  logic               digit_strobe_c, key_err_c;

  key_press_detect u_detect (
    .clk            (clk),
    .rst            (rst),
    .key_in         (bus.key_in),
    .digit_c        (digit_c),
    .digit_strobe_c (digit_strobe_c),
    .key_err_c      (key_err_c)
  );

  // Mask covering the low n nibbles of the buffer.
  function automatic logic [BUF_W-1:0] low_mask(input logic [CNT_W-1:0] n);
    logic [BUF_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i < int'(n)) m[i*NIB_W +: NIB_W] = '1;
    end
    return m;
  endfunction

  assign enter_p     = bus.enter & ~enter_q;
  assign clear_p     = bus.clear & ~clear_q;
  assign lock_p      = bus.lock  & ~lock_q;
  assign attempt_inc = bcd_inc(attempt_q);
  assign code_ok     = (cnt_q == len_q) &&
                       ((buf_q & low_mask(cnt_q)) == (code_q & low_mask(len_q)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LOCKED;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    len_d         = len_q;
    attempt_d     = attempt_q;
    timer_d       = timer_q;
    digit_out_d   = digit_out_q;
    digit_valid_d = 1'b0;
    key_err_d     = 1'b0;
    match_d       = 1'b0;
    fail_d        = 1'b0;
    code_set_d    = 1'b0;
    clr_buf       = 1'b0;
    take_digit    = 1'b0;

    if (state_q != S_LOCKOUT) key_err_d = key_err_c;

    unique case (state_q)
      S_LOCKED, S_ENTRY: begin
        if (clear_p) begin
          clr_buf = 1'b1;
        end else if (enter_p) begin
          if (cnt_q != '0) begin
            clr_buf = 1'b1;
            if (code_ok) begin
              match_d   = 1'b1;
              attempt_d = '0;
              state_d   = S_OPEN;
            end else begin
              fail_d    = 1'b1;
              attempt_d = attempt_inc;
              if (attempt_inc == 4'(MAX_ATTEMPTS)) begin
                timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
                state_d = S_LOCKOUT;
              end else begin
                state_d = S_LOCKED;
              end
            end
          end
        end else if (digit_strobe_c) begin
          take_digit = 1'b1;
          state_d    = S_ENTRY;
        end
      end
      S_OPEN: begin
        if (lock_p) begin
          clr_buf = 1'b1;
          state_d = S_LOCKED;
        end else if (bus.mode_sel) begin
          clr_buf = 1'b1;
          state_d = S_SET;
        end else if (clear_p) begin
          clr_buf = 1'b1;
        end
      end
      S_SET: begin
        if (lock_p) begin
          clr_buf = 1'b1;
          state_d = S_LOCKED;
        end else if (clear_p) begin
          clr_buf = 1'b1;
        end else if (enter_p) begin
          if (cnt_q >= CNT_W'(MIN_LEN)) begin
            code_d     = buf_q;
            len_d      = cnt_q;
            code_set_d = 1'b1;
            clr_buf    = 1'b1;
            state_d    = S_LOCKED;
          end
        end else if (digit_strobe_c) begin
          take_digit = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          attempt_d = '0;
          state_d   = S_LOCKED;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = S_LOCKED;
    endcase

    // A full buffer silently drops further digits.
    if (clr_buf) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (take_digit && (cnt_q != CNT_W'(DIGITS))) begin
      buf_d         = {buf_q[BUF_W-NIB_W-1:0], digit_c};
      cnt_d         = cnt_q + CNT_W'(1);
      digit_valid_d = 1'b1;
      digit_out_d   = digit_c;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q         <= '0;
      cnt_q         <= '0;
      code_q        <= DEFAULT_CODE;
      len_q         <= CNT_W'(DEFAULT_LEN);
      attempt_q     <= '0;
      timer_q       <= '0;
      digit_out_q   <= '0;
      digit_valid_q <= 1'b0;
      key_err_q     <= 1'b0;
      match_q       <= 1'b0;
      fail_q        <= 1'b0;
      code_set_q    <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
      programming_q <= 1'b0;
      enter_q       <= 1'b0;
      clear_q       <= 1'b0;
      lock_q        <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      len_q         <= len_d;
      attempt_q     <= attempt_d;
      timer_q       <= timer_d;
      digit_out_q   <= digit_out_d;
      digit_valid_q <= digit_valid_d;
      key_err_q     <= key_err_d;
      match_q       <= match_d;
      fail_q        <= fail_d;
      code_set_q    <= code_set_d;
      unlocked_q    <= (state_d == S_OPEN) || (state_d == S_SET);
      locked_out_q  <= (state_d == S_LOCKOUT);
      programming_q <= (state_d == S_SET);
      enter_q       <= bus.enter;
      clear_q       <= bus.clear;
      lock_q        <= bus.lock;
    end
  end

  assign bus.unlocked      = unlocked_q;
  assign bus.locked_out    = locked_out_q;
  assign bus.programming   = programming_q;
  assign bus.entry_count   = cnt_q;
  assign bus.digit_out     = digit_out_q;
  assign bus.digit_valid   = digit_valid_q;
  assign bus.key_err       = key_err_q;
  assign bus.match         = match_q;
  assign bus.fail          = fail_q;
  assign bus.code_set      = code_set_q;
  assign bus.attempt_count = attempt_q;

endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
- Clocked, parametrised successor to the ripple-clocked keypad / shift-register / comparator lock path.
- Takes a raw 10-key one-hot keypad and edge-detects presses.
- Buffers a variable-length passcode (MIN_LEN..DIGITS nibbles), compares it against a stored code, and counts failed attempts in BCD.
- Enforces a timed lockout; allows re-programming the code only while unlocked. Sits between the keypad encoder input and the door actuator/status display.

Parameters:
- DIGITS, 8: maximum code length in BCD nibbles.
- MIN_LEN, 4: minimum accepted length when setting a new code.
- MAX_ATTEMPTS, 3: failed entries before lockout; range 1..9.
- LOCKOUT_CYCLES, 1024: clock cycles spent in lockout.
- DEFAULT_CODE, 32'h21935488: reset code, first digit in the MS nibble, width DIGITS*4.
- DEFAULT_LEN, 8: reset code length.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- key_in, in, 10: keypad lines; bit k = digit k.
- enter, in, 1: submit level, edge-detected internally.
- clear, in, 1: discard buffer level, edge-detected.
- lock, in, 1: relock request level, edge-detected.
- mode_sel, in, 1: 1 = program new code (honoured only in S_OPEN).
- unlocked, out, 1: actuator drive.
- locked_out, out, 1: high during lockout.
- programming, out, 1: high in S_SET.
- entry_count, out, $clog2(DIGITS+1): digits currently buffered.
- digit_out, out, 4: last accepted digit, BCD.
- digit_valid, out, 1: 1-cycle pulse per accepted digit.
- key_err, out, 1: 1-cycle pulse on multi-key press.
- match, out, 1: 1-cycle pulse on correct code.
- fail, out, 1: 1-cycle pulse on wrong code.
- code_set, out, 1: 1-cycle pulse when a new code is stored.
- attempt_count, out, 4: failed attempts, BCD 0..MAX_ATTEMPTS.

Behaviour:
- Reset (async assert, sync release) sets:
  - state S_LOCKED, buffer 0, entry_count 0, attempt_count 0;
  - all pulses 0, unlocked 0, locked_out 0;
  - stored code = DEFAULT_CODE, length DEFAULT_LEN;
  - edge registers 0.
- Press detection:
  - A press is accepted when key_in is one-hot while the previous registered key_in was 0.
  - If key_in has popcount>1 on the transition from 0: key_err pulses, no digit.
  - Changes while keys are held are ignored until all keys are released.
- Accepted digit: the nibble shifts into the buffer LS end, entry_count++, digit_valid and digit_out are registered. Latency is 1 cycle from the sampled press.
- Buffer full (entry_count==DIGITS): further digits are dropped with no wrap and no error; digit_valid stays 0.
- Priority within one cycle: clear > enter > digit. A digit coincident with enter/clear is discarded.
- clear: empties the buffer and count. It is not an attempt and does not change state.
- States:
  - S_LOCKED: a digit moves to S_ENTRY.
  - S_ENTRY: on enter, compare length AND the low length*4 bits of buffer vs stored code.
    - Match: match pulse, attempt_count←0, → S_OPEN. unlocked=1 on the next edge.
    - Mismatch: fail pulse, attempt_count++ in BCD. If the new count == MAX_ATTEMPTS → S_LOCKOUT, else → S_LOCKED.
    - The buffer clears in both cases.
    - enter with entry_count==0 is ignored.
  - S_OPEN: unlocked=1.
    - lock → S_LOCKED.
    - mode_sel=1 → S_SET, buffer cleared.
  - S_SET: programming=1, unlocked stays 1.
    - enter with entry_count ≥ MIN_LEN stores buffer+length, pulses code_set, → S_LOCKED.
    - enter with entry_count < MIN_LEN is ignored.
    - lock aborts → S_LOCKED, code unchanged.
  - S_LOCKOUT: locked_out=1. Keys, enter and clear are ignored (key_err still suppressed). A down-counter loads LOCKOUT_CYCLES-1 and on reaching 0 → S_LOCKED with attempt_count←0.
- Reset mid-operation: the stored code reverts to DEFAULT_CODE; there is no retention.

Decomposition:
- Shared package / include holds:
  - state encodings S_LOCKED, S_ENTRY, S_OPEN, S_SET, S_LOCKOUT (3-bit);
  - the one-hot→BCD key encode function;
  - the BCD increment function.
- One sub-module, key_press_detect: edge/one-hot check producing digit, digit_strobe and key_err.
- FSM, buffer, code store and timer live in the top.

Test Plan:
- Reset, then press 2,1,9,3,5,4,8,8, enter → match pulse, unlocked=1 one cycle later, attempt_count=0.
- Press 2,1,9,3,5,4,7,7, enter three times → fail ×3, attempt_count 1,2,3. locked_out=1 for exactly 1024 cycles, then S_LOCKED with attempt_count=0. Keys during lockout produce no digit_valid.
- While unlocked: mode_sel=1, press 4,3,2, enter → ignored (<MIN_LEN). Press 1 more then enter → code_set, locked. Entering 4,3,2,1 unlocks; the old 8-digit code fails.
- key_in=10'b0000100100 from idle → key_err pulse, entry_count unchanged. Holding key 5 then adding key 6 → a single digit 5 only.
- Press 9 digits → entry_count saturates at 8, ninth press gives no digit_valid. Same-cycle enter+clear → buffer cleared, no attempt counted.
- Drop rst low mid-entry after 3 digits → all outputs 0 immediately (asynchronously). After release, the default code unlocks.
